// File: rtl/legv8_defs.sv
// ----------------------------------------------------------------------------
// legv8_defs
// Shared definitions for the instruction fetch slice: instruction width,
// the unconditional-branch opcode, the halt sentinel word and the fetch
// state encoding. Imported by instr_fetch_unit and next_pc_calc.
// ----------------------------------------------------------------------------
package legv8_defs;

    localparam int          INSN_W    = 32;
    localparam logic [5:0]  OPC_B     = 6'b000101;
    // BR XZR: treated as the end-of-program marker by fetch
    localparam logic [31:0] HALT_INSN = 32'hD600_03E0;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// ----------------------------------------------------------------------------
// next_pc_calc
// Purely combinational successor-PC logic for the fetch unit.
// Ports:
//   pc       in   PC_W    byte PC of the word currently returned by the ROM
//   instr    in   INSN_W  instruction word at pc
//   next_pc  out  PC_W    pc + 4, or the B target when instr is a B
//   is_b     out  1       instr is an unconditional B
//   is_halt  out  1       instr is the halt sentinel
// ----------------------------------------------------------------------------
module next_pc_calc
    import legv8_defs::*;
#(
    parameter int PC_W = 64
) (
    input  logic [PC_W-1:0]   pc,
    input  logic [INSN_W-1:0] instr,
    output logic [PC_W-1:0]   next_pc,
    output logic              is_b,
    output logic              is_halt
);

    // imm26 is a word offset: sign-extend to the PC width and scale by 4
    logic [PC_W-1:0] b_offset;

    assign b_offset = {{(PC_W-28){instr[25]}}, instr[25:0], 2'b00};
    assign is_b     = (instr[31:26] == OPC_B);
    assign is_halt  = (instr == HALT_INSN);
    assign next_pc  = is_b ? (pc + b_offset) : (pc + PC_W'(4));

endmodule

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
// Owns the PC, addresses a combinational instruction ROM and hands
// {instr, pc} to decode through a single valid/ready output register.
// Unconditional B is resolved at fetch; EX-stage redirects flush and
// refetch; fetching stops on the halt sentinel until a redirect.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   imem_addr       out  word address to the ROM (from the pc register)
//   imem_data       in   ROM word for imem_addr, same cycle
//   if_valid/if_instr/if_pc  out  decode-side output register
//   id_ready        in   decode accepts the output register this cycle
//   redirect_valid/redirect_pc  in  flush and restart at redirect_pc
//   halted          out  halt sentinel fetched, fetching stopped
//   instr_count     out  saturating count of accepted handshakes
// ----------------------------------------------------------------------------
module instr_fetch_unit
    import legv8_defs::*;
#(
    parameter int              ADDR_W   = 16,
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INSN_W-1:0] imem_data,
    output logic              if_valid,
    output logic [INSN_W-1:0] if_instr,
    output logic [PC_W-1:0]   if_pc,
    input  logic              id_ready,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              halted,
    output logic [31:0]       instr_count
);

    fetch_state_e      state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              if_valid_q, if_valid_d;
    logic [INSN_W-1:0] if_instr_q, if_instr_d;
    logic [PC_W-1:0]   if_pc_q, if_pc_d;
    logic              halted_q, halted_d;
    logic [31:0]       count_q, count_d;

    logic [PC_W-1:0]   seq_next_pc;
    logic              fetch_is_b;
    logic              fetch_is_halt;
    logic              handshake;
    logic              can_load;

    next_pc_calc #(
        .PC_W (PC_W)
    ) u_next_pc (
        .pc      (pc_q),
        .instr   (imem_data),
        .next_pc (seq_next_pc),
        .is_b    (fetch_is_b),
        .is_halt (fetch_is_halt)
    );

    assign imem_addr   = pc_q[ADDR_W+1:2];
    assign if_valid    = if_valid_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign halted      = halted_q;
    assign instr_count = count_q;

    assign handshake = if_valid_q & id_ready;
    assign can_load  = (state_q == FETCH) & (~if_valid_q | id_ready);

    // Redirect outranks everything (stall, halt, a B being fetched). When
    // the register is free in FETCH, the ROM word is captured; the halt
    // sentinel is delivered but freezes the pc. In HALT the last word only
    // drains. The B decode result is not needed here beyond next_pc.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        halted_d   = halted_q;
        count_d    = count_q;

        if (handshake && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end

        if (redirect_valid) begin
            pc_d       = redirect_pc & ~PC_W'(3);
            if_valid_d = 1'b0;
            state_d    = FETCH;
            halted_d   = 1'b0;
        end else if (can_load) begin
            if_instr_d = imem_data;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            if (fetch_is_halt) begin
                state_d  = HALT;
                halted_d = 1'b1;
            end else begin
                pc_d = seq_next_pc;
            end
        end else if (handshake) begin
            if_valid_d = 1'b0;
        end
    end

    logic unused_is_b;
    assign unused_is_b = fetch_is_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_instr_q <= '0;
            if_pc_q    <= '0;
            halted_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            halted_q   <= halted_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed scenarios followed by a randomized run of instr_fetch_unit
// against a program-order model of the instruction stream.
// ----------------------------------------------------------------------------
module tb_instr_fetch_unit;
    import legv8_defs::*;

    localparam int ADDR_W = 16;
    localparam int PC_W   = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              if_valid;
    logic [31:0]       if_instr;
    logic [PC_W-1:0]   if_pc;
    logic              id_ready = 1'b0;
    logic              redirect_valid = 1'b0;
    logic [PC_W-1:0]   redirect_pc = '0;
    logic              halted;
    logic [31:0]       instr_count;

    logic [31:0] rom [0:65535];

    int testsRun = 0;
    int testsFailed = 0;
    int expCount = 0;

    // Free-running clock, period 10
    always #5 clk = ~clk;

    // Combinational instruction ROM
    assign imem_data = rom[imem_addr];

    instr_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .PC_W     (PC_W),
        .RESET_PC ('0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .id_ready       (id_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .instr_count    (instr_count)
    );

    // One comparison: count it, and report it if it does not hold
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Drive inputs at a falling edge, note whether the coming rising edge
    // completes a handshake, then wait for the next falling edge
    task automatic applyStimulus(input logic rdy, input logic rv, input logic [63:0] rpc);
        id_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (rst_n && if_valid && rdy) expCount++;
        @(negedge clk);
    endtask

    function automatic logic [31:0] makeB(input int fromWord, input int toWord);
        logic [25:0] off;
        off = 26'(toWord - fromWord);
        return {OPC_B, off};
    endfunction

    logic [63:0] mpc;
    logic        mHalted;
    logic        haltAccepted;
    logic        rdy;
    logic        rv;
    logic [63:0] rpc;
    logic [31:0] word;
    int          nHandshakes;

    initial begin
        for (int i = 0; i < 65536; i++) rom[i] = 32'h8B00_0000 | 32'(i);
        rom[0]  = 32'h9100_0421;
        rom[1]  = 32'hD280_0020;
        rom[2]  = 32'hD280_0041;
        rom[9]  = 32'h17FF_FFF9;
        rom[17] = HALT_INSN;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_valid", if_valid, 0);
        checkOutput("rst_halted", halted, 0);
        checkOutput("rst_count", instr_count, 0);
        checkOutput("rst_addr", imem_addr, 0);
        checkOutput("rst_pc", if_pc, 0);
        checkOutput("rst_instr", if_instr, 0);
        rst_n = 1'b1;

        // Sequential stream from word 0
        applyStimulus(1, 0, 0);
        checkOutput("t1_addr1", imem_addr, 1);
        checkOutput("t1_valid", if_valid, 1);
        checkOutput("t1_pc0", if_pc, 0);
        checkOutput("t1_instr0", if_instr, 32'h9100_0421);
        applyStimulus(1, 0, 0);
        checkOutput("t1_addr2", imem_addr, 2);
        checkOutput("t1_pc4", if_pc, 4);
        applyStimulus(1, 0, 0);
        checkOutput("t1_addr3", imem_addr, 3);
        checkOutput("t1_pc8", if_pc, 8);
        checkOutput("t1_count2", instr_count, 2);
        applyStimulus(1, 0, 0);
        checkOutput("t1_count3", instr_count, 3);
        checkOutput("t1_pcC", if_pc, 12);

        // Backward B at word 9 jumps to word 2
        for (int n = 0; n < 20 && imem_addr != 16'd9; n++) applyStimulus(1, 0, 0);
        checkOutput("t2_reach_b", imem_addr, 9);
        applyStimulus(1, 0, 0);
        checkOutput("t2_target", imem_addr, 2);
        checkOutput("t2_b_pc", if_pc, 64'h24);
        checkOutput("t2_b_instr", if_instr, 32'h17FF_FFF9);
        applyStimulus(1, 0, 0);
        checkOutput("t2_after_pc", if_pc, 8);
        checkOutput("t2_after_addr", imem_addr, 3);

        // Stall for 4 cycles, then release
        for (int n = 0; n < 4; n++) begin
            applyStimulus(0, 0, 0);
            checkOutput("t3_hold_pc", if_pc, 8);
            checkOutput("t3_hold_instr", if_instr, rom[2]);
            checkOutput("t3_hold_addr", imem_addr, 3);
            checkOutput("t3_hold_valid", if_valid, 1);
            checkOutput("t3_hold_count", instr_count, expCount);
        end
        applyStimulus(1, 0, 0);
        checkOutput("t3_resume_pc", if_pc, 12);
        checkOutput("t3_resume_addr", imem_addr, 4);
        applyStimulus(1, 0, 0);
        checkOutput("t3_next_pc", if_pc, 16);
        checkOutput("t3_count", instr_count, expCount);

        // Redirect while stalled
        applyStimulus(0, 0, 0);
        checkOutput("t4_stall_pc", if_pc, 16);
        applyStimulus(0, 1, 64'h1B);
        checkOutput("t4_flush_valid", if_valid, 0);
        checkOutput("t4_addr", imem_addr, 6);
        checkOutput("t4_count", instr_count, expCount);
        applyStimulus(1, 0, 0);
        checkOutput("t4_resume_valid", if_valid, 1);
        checkOutput("t4_resume_pc", if_pc, 64'h18);
        checkOutput("t4_resume_instr", if_instr, rom[6]);

        // Halt sentinel at word 17, then redirect out of halt
        applyStimulus(1, 1, 64'h40);
        checkOutput("t5_redir_valid", if_valid, 0);
        checkOutput("t5_redir_addr", imem_addr, 16);
        applyStimulus(1, 0, 0);
        checkOutput("t5_pc40", if_pc, 64'h40);
        applyStimulus(1, 0, 0);
        checkOutput("t5_halt_instr", if_instr, HALT_INSN);
        checkOutput("t5_halt_pc", if_pc, 64'h44);
        checkOutput("t5_halted", halted, 1);
        checkOutput("t5_halt_addr", imem_addr, 17);
        applyStimulus(1, 0, 0);
        checkOutput("t5_drained", if_valid, 0);
        checkOutput("t5_still_halted", halted, 1);
        applyStimulus(1, 0, 0);
        checkOutput("t5_no_refetch", if_valid, 0);
        checkOutput("t5_frozen_addr", imem_addr, 17);
        checkOutput("t5_count", instr_count, expCount);
        applyStimulus(1, 1, 0);
        checkOutput("t5_unhalt", halted, 0);
        checkOutput("t5_unhalt_addr", imem_addr, 0);
        applyStimulus(1, 0, 0);
        checkOutput("t5_refetch_pc", if_pc, 0);
        checkOutput("t5_refetch_valid", if_valid, 1);

        // Asynchronous reset in the middle of a stall
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        #2 rst_n = 1'b0;
        expCount = 0;
        #1;
        checkOutput("t6_async_valid", if_valid, 0);
        checkOutput("t6_async_instr", if_instr, 0);
        checkOutput("t6_async_pc", if_pc, 0);
        checkOutput("t6_async_count", instr_count, 0);
        checkOutput("t6_async_addr", imem_addr, 0);
        checkOutput("t6_async_halted", halted, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // PC wrap at the top of the address space
        applyStimulus(1, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        checkOutput("t6_top_addr", imem_addr, 16'hFFFF);
        applyStimulus(1, 0, 0);
        checkOutput("t6_top_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        checkOutput("t6_top_instr", if_instr, rom[65535]);
        checkOutput("t6_wrap_addr", imem_addr, 0);
        applyStimulus(1, 0, 0);
        checkOutput("t6_wrap_pc", if_pc, 0);

        // Random program in words 0x100..0x13F, closed by a B back to 0x100
        for (int w = 16'h100; w < 16'h140; w++) begin
            int r;
            r = $urandom_range(0, 31);
            if (r < 4) begin
                rom[w] = makeB(w, $urandom_range(16'h100, 16'h13F));
            end else if (r == 4) begin
                rom[w] = HALT_INSN;
            end else begin
                word = $urandom();
                if (word[31:26] == OPC_B) word[31] = 1'b1;
                if (word == HALT_INSN) word[0] = 1'b1;
                rom[w] = word;
            end
        end
        rom[16'h140] = makeB(16'h140, 16'h100);

        // Model: the address decode must see next, in program order
        applyStimulus(1, 1, 64'h400);
        mpc = 64'h400;
        mHalted = 1'b0;
        nHandshakes = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 39) == 0) || (mHalted && ($urandom_range(0, 5) == 0));
            rpc = 64'h400 + 64'($urandom_range(0, 255));
            haltAccepted = 1'b0;
            if (if_valid && rdy) begin
                checkOutput("rnd_extra_delivery", mHalted, 0);
                checkOutput("rnd_pc", if_pc, mpc);
                checkOutput("rnd_instr", if_instr, rom[mpc[17:2]]);
                word = rom[mpc[17:2]];
                if (word == HALT_INSN) begin
                    checkOutput("rnd_halted_early", halted, 1);
                    mHalted = 1'b1;
                    haltAccepted = 1'b1;
                end else if (word[31:26] == OPC_B) begin
                    mpc = mpc + {{36{word[25]}}, word[25:0], 2'b00};
                end else begin
                    mpc = mpc + 64'd4;
                end
                nHandshakes++;
            end
            if (rv) begin
                mpc = rpc & ~64'd3;
                mHalted = 1'b0;
            end
            applyStimulus(rdy, rv, rpc);
            checkOutput("rnd_count", instr_count, expCount);
            if (rv) begin
                checkOutput("rnd_redir_valid", if_valid, 0);
                checkOutput("rnd_redir_halted", halted, 0);
            end else if (haltAccepted) begin
                checkOutput("rnd_halt_drain", if_valid, 0);
                checkOutput("rnd_halt_flag", halted, 1);
            end
        end
        checkOutput("rnd_progress", (nHandshakes > 500), 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
